lstm_sequencer: RTL and testbench

- Upstream driver for the single-cell LSTM datapath.
- Buffers a stream of input samples x[t] with sequence boundaries (last flag).
- Launches one cell step at a time using the cell's ready/valid timing, and injects initial h/C on the first step of each sequence.
- Captures each step's y_out/C_out into a backpressured output register; a watchdog detects a cell that never completes a step.

---
 rtl/lstm_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_lstm_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lstm_sequencer.sv
// Upstream sequencer for the single-cell LSTM datapath: buffers x[t] samples,
// launches one cell step at a time, injects h0/C0 on sequence starts and captures results.
module lstm_sequencer #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned TIMEOUT    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_x,
    input  logic             s_last,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] h0,
    input  logic [WIDTH-1:0] C0,
    input  logic             cell_ready,
    output logic [WIDTH-1:0] cell_x,
    output logic             cell_x_valid,
    output logic [WIDTH-1:0] cell_h,
    output logic             cell_h_valid,
    output logic [WIDTH-1:0] cell_C,
    output logic             cell_C_valid,
    input  logic [WIDTH-1:0] cell_y,
    input  logic [WIDTH-1:0] cell_C_out,
    input  logic             cell_valid,
    output logic [WIDTH-1:0] m_y,
    output logic [WIDTH-1:0] m_C,
    output logic             m_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] step_cnt,
    output logic             busy,
    output logic             err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             first_step_q, first_step_d;
    logic             inflight_last_q, inflight_last_d;
    logic             err_q, err_d;
    logic             m_valid_q, m_valid_d;
    logic             m_last_q, m_last_d;
    logic [WIDTH-1:0] m_y_q, m_y_d;
    logic [WIDTH-1:0] m_c_q, m_c_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             push;
    logic             launch;
    logic             head_last;

    // Show-ahead FIFO head feeds the cell directly; h/C pass straight through.
    assign s_ready      = level_q < LVL_W'(FIFO_DEPTH);
    assign push         = s_valid && s_ready;
    assign cell_x       = mem_q[rd_ptr_q][WIDTH-1:0];
    assign head_last    = mem_q[rd_ptr_q][WIDTH];
    assign launch       = (state_q == LAUNCH) && cell_ready;
    assign cell_x_valid = launch;
    assign cell_h_valid = launch && first_step_q;
    assign cell_C_valid = launch && first_step_q;
    assign cell_h       = h0;
    assign cell_C       = C0;

    assign m_y      = m_y_q;
    assign m_C      = m_c_q;
    assign m_last   = m_last_q;
    assign m_valid  = m_valid_q;
    assign step_cnt = step_cnt_q;
    assign busy     = state_q != IDLE;
    assign err      = err_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_last, s_x};
        end
    end

    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        level_d         = level_q;
        first_step_d    = first_step_q;
        inflight_last_d = inflight_last_q;
        err_d           = err_q;
        m_valid_d       = m_valid_q;
        m_last_d        = m_last_q;
        m_y_d           = m_y_q;
        m_c_d           = m_c_q;
        step_cnt_d      = step_cnt_q;
        wd_d            = wd_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (launch) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, launch})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (m_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Launch only with an empty output register: cell_valid cannot be stalled.
                if ((level_q != '0) && !m_valid_q) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                if (cell_ready) begin
                    inflight_last_d = head_last;
                    first_step_d    = 1'b0;
                    // wd_q tracks cycles elapsed since the launch cycle.
                    wd_d            = WD_W'(1);
                    state_d         = WAIT;
                end
            end
            WAIT: begin
                if (cell_valid) begin
                    m_y_d     = cell_y;
                    m_c_d     = cell_C_out;
                    m_last_d  = inflight_last_q;
                    m_valid_d = 1'b1;
                    if (inflight_last_q) begin
                        first_step_d = 1'b1;
                        step_cnt_d   = '0;
                    end else begin
                        step_cnt_d = step_cnt_q + CNT_W'(1);
                    end
                    state_d = IDLE;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    err_d        = 1'b1;
                    first_step_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
            first_step_q    <= 1'b1;
            inflight_last_q <= 1'b0;
            err_q           <= 1'b0;
            m_valid_q       <= 1'b0;
            m_last_q        <= 1'b0;
            m_y_q           <= '0;
            m_c_q           <= '0;
            step_cnt_q      <= '0;
            wd_q            <= '0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            level_q         <= level_d;
            first_step_q    <= first_step_d;
            inflight_last_q <= inflight_last_d;
            err_q           <= err_d;
            m_valid_q       <= m_valid_d;
            m_last_q        <= m_last_d;
            m_y_q           <= m_y_d;
            m_c_q           <= m_c_d;
            step_cnt_q      <= step_cnt_d;
            wd_q            <= wd_d;
        end
    end

endmodule

// File: tb/tb_lstm_sequencer.sv
// Directed bench for lstm_sequencer with a 7-cycle toy cell: y = h + x, C = C - x,
// state recirculates unless h/C valids inject new values.
module tb_lstm_sequencer;

    localparam int unsigned TIMEOUT = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] s_x;
    logic        s_last;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] h0;
    logic [15:0] C0;
    logic        cell_ready;
    logic [15:0] cell_x;
    logic        cell_x_valid;
    logic [15:0] cell_h;
    logic        cell_h_valid;
    logic [15:0] cell_C;
    logic        cell_C_valid;
    logic [15:0] cell_y;
    logic [15:0] cell_C_out;
    logic        cell_valid;
    logic [15:0] m_y;
    logic [15:0] m_C;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  step_cnt;
    logic        busy;
    logic        err;

    lstm_sequencer #(
        .WIDTH(16), .FIFO_DEPTH(8), .CNT_W(8), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .s_x(s_x), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .h0(h0), .C0(C0),
        .cell_ready(cell_ready),
        .cell_x(cell_x), .cell_x_valid(cell_x_valid),
        .cell_h(cell_h), .cell_h_valid(cell_h_valid),
        .cell_C(cell_C), .cell_C_valid(cell_C_valid),
        .cell_y(cell_y), .cell_C_out(cell_C_out), .cell_valid(cell_valid),
        .m_y(m_y), .m_C(m_C), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .step_cnt(step_cnt), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Toy cell: fixed 7-cycle pipeline, launch log for h/C-valid checks.
    logic [6:0]  pv = '0;
    logic [15:0] py [7];
    logic [15:0] pc [7];
    logic [15:0] st_h = '0;
    logic [15:0] st_c = '0;
    logic [15:0] src_h, src_c, new_y, new_c;
    logic        suppress = 1'b0;
    logic        lg_hv [64];
    logic        lg_cv [64];
    int          lg_n = 0;

    assign src_h = cell_h_valid ? cell_h : st_h;
    assign src_c = cell_C_valid ? cell_C : st_c;
    assign new_y = src_h + cell_x;
    assign new_c = src_c - cell_x;
    assign cell_valid = pv[6] && !suppress;
    assign cell_y     = py[6];
    assign cell_C_out = pc[6];

    always @(posedge clk) begin
        pv    <= {pv[5:0], cell_x_valid};
        py[0] <= new_y;
        pc[0] <= new_c;
        for (int i = 1; i < 7; i++) begin
            py[i] <= py[i-1];
            pc[i] <= pc[i-1];
        end
        if (cell_x_valid) begin
            st_h        <= new_y;
            st_c        <= new_c;
            lg_hv[lg_n] <= cell_h_valid;
            lg_cv[lg_n] <= cell_C_valid;
            lg_n        <= lg_n + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int out_cyc  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] x, input logic last);
        int n = 0;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check_eq("push_ready", 32'(s_ready), 32'd1);
        s_x     = x;
        s_last  = last;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] y, input logic [15:0] c,
                              input logic last, input logic [7:0] cnt);
        int n = 0;
        while (!m_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        out_cyc = cyc;
        check_eq({tag, "_valid"}, 32'(m_valid), 32'd1);
        check_eq({tag, "_y"}, 32'(m_y), 32'(y));
        check_eq({tag, "_C"}, 32'(m_C), 32'(c));
        check_eq({tag, "_last"}, 32'(m_last), 32'(last));
        check_eq({tag, "_cnt"}, 32'(step_cnt), 32'(cnt));
        @(negedge clk);
    endtask

    initial begin
        int base;
        int t_w;
        int n;
        logic [15:0] ey;
        logic seen_v, seen_b;

        rst = 1'b0; s_x = '0; s_last = 1'b0; s_valid = 1'b0;
        h0 = '0; C0 = '0; cell_ready = 1'b1; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_m_valid", 32'(m_valid), 32'd0);
        check_eq("rst_s_ready", 32'(s_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_cnt", 32'(step_cnt), 32'd0);
        check_eq("rst_xv", 32'(cell_x_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single sequence with latency check on the first sample.
        h0 = 16'h0040; C0 = 16'hFFC0;
        base = lg_n;
        push(16'h0100, 1'b0);
        t_w = cyc;
        push(16'h0080, 1'b0);
        push(16'hFF00, 1'b1);
        expect_out("s1", 16'h0140, 16'hFEC0, 1'b0, 8'd1);
        check_eq("latency", 32'(out_cyc - t_w), 32'd9);
        expect_out("s2", 16'h01C0, 16'hFE40, 1'b0, 8'd2);
        expect_out("s3", 16'h00C0, 16'hFF40, 1'b1, 8'd0);
        check_eq("s_hv0", 32'(lg_hv[base]), 32'd1);
        check_eq("s_cv0", 32'(lg_cv[base]), 32'd1);
        check_eq("s_hv1", 32'(lg_hv[base+1]), 32'd0);
        check_eq("s_cv2", 32'(lg_cv[base+2]), 32'd0);

        // Two back-to-back sequences with different initial state.
        h0 = 16'h0100; C0 = 16'h0200;
        base = lg_n;
        push(16'h0010, 1'b0);
        push(16'h0020, 1'b1);
        push(16'h0003, 1'b0);
        push(16'h0004, 1'b1);
        expect_out("a1", 16'h0110, 16'h01F0, 1'b0, 8'd1);
        h0 = 16'h1000; C0 = 16'h0000;
        expect_out("a2", 16'h0130, 16'h01D0, 1'b1, 8'd0);
        expect_out("b1", 16'h1003, 16'hFFFD, 1'b0, 8'd1);
        expect_out("b2", 16'h1007, 16'hFFF9, 1'b1, 8'd0);
        check_eq("bb_hv0", 32'(lg_hv[base]), 32'd1);
        check_eq("bb_hv1", 32'(lg_hv[base+1]), 32'd0);
        check_eq("bb_hv2", 32'(lg_hv[base+2]), 32'd1);
        check_eq("bb_cv2", 32'(lg_cv[base+2]), 32'd1);
        check_eq("bb_hv3", 32'(lg_hv[base+3]), 32'd0);

        // Output backpressure: no launch while m_valid, FIFO fills, drains in order.
        m_ready = 1'b0; h0 = '0; C0 = '0;
        push(16'd1, 1'b0);
        expect_out("bp1", 16'd1, 16'hFFFF, 1'b0, 8'd1);
        base = lg_n;
        for (int k = 2; k <= 9; k++) push(16'(k), k == 9);
        check_eq("bp_full", 32'(s_ready), 32'd0);
        repeat (30) @(negedge clk);
        check_eq("bp_hold_v", 32'(m_valid), 32'd1);
        check_eq("bp_hold_y", 32'(m_y), 32'd1);
        check_eq("bp_no_launch", 32'(lg_n), 32'(base));
        check_eq("bp_idle", 32'(busy), 32'd0);
        m_ready = 1'b1;
        @(negedge clk);
        for (int k = 2; k <= 9; k++) begin
            ey = 16'(k * (k + 1) / 2);
            expect_out($sformatf("bp%0d", k), ey, 16'(-ey), k == 9, (k == 9) ? 8'd0 : 8'(k));
        end

        // Cell not ready: hold in LAUNCH without popping.
        cell_ready = 1'b0; h0 = 16'h0005; C0 = 16'h0006;
        base = lg_n;
        push(16'h0010, 1'b1);
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("cr_hold%0d", i), 32'(cell_x_valid), 32'd0);
            @(negedge clk);
        end
        check_eq("cr_no_pop", 32'(lg_n), 32'(base));
        cell_ready = 1'b1;
        #1;
        check_eq("cr_xv", 32'(cell_x_valid), 32'd1);
        check_eq("cr_hv", 32'(cell_h_valid), 32'd1);
        expect_out("cr", 16'h0015, 16'hFFF6, 1'b1, 8'd0);

        // Watchdog: cell never answers.
        suppress = 1'b1; h0 = 16'h0007; C0 = 16'h0008;
        push(16'h0011, 1'b0);
        n = 0;
        while (!cell_x_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("wd_launch", 32'(cell_x_valid), 32'd1);
        n = 0;
        while (!err && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("wd_cycles", 32'(n), 32'(TIMEOUT));
        check_eq("wd_idle", 32'(busy), 32'd0);
        check_eq("wd_no_out", 32'(m_valid), 32'd0);
        suppress = 1'b0;
        push(16'h0012, 1'b1);
        expect_out("wd_next", 16'h0019, 16'hFFF6, 1'b1, 8'd0);
        check_eq("wd_next_hv", 32'(lg_hv[lg_n-1]), 32'd1);
        check_eq("wd_sticky", 32'(err), 32'd1);

        // Reset mid-WAIT with samples queued; late cell_valid must be ignored.
        h0 = 16'h0100; C0 = '0;
        base = lg_n;
        for (int k = 1; k <= 4; k++) push(16'(k), 1'b0);
        repeat (2) @(negedge clk);
        check_eq("rw_inflight", 32'(lg_n), 32'(base + 1));
        check_eq("rw_busy_pre", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("rw_busy", 32'(busy), 32'd0);
        check_eq("rw_err", 32'(err), 32'd0);
        check_eq("rw_s_ready", 32'(s_ready), 32'd1);
        check_eq("rw_m_valid", 32'(m_valid), 32'd0);
        check_eq("rw_cnt", 32'(step_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen_v = 1'b0; seen_b = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            seen_v = seen_v | m_valid;
            seen_b = seen_b | busy;
        end
        check_eq("rw_late_ignored", 32'(seen_v), 32'd0);
        check_eq("rw_fifo_empty", 32'(seen_b), 32'd0);
        h0 = 16'h0001; C0 = 16'h0001;
        push(16'h0001, 1'b1);
        expect_out("rw_after", 16'h0002, 16'h0000, 1'b1, 8'd0);
        check_eq("rw_after_hv", 32'(lg_hv[lg_n-1]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
